// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, glitch filter and edge qualifier with pulse/sticky/overflow flags and one irq.
// Latency: data_in settling before edge 1 gives evt_pulse high after edge SYNC_STAGES+filt_len+1; irq follows flags combinationally.
// No backpressure: events are never stalled; a repeat event on an already-set sticky flag is recorded as overflow.
module edge_detect_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [WIDTH-1:0]     clr,
  input  logic [WIDTH-1:0]     irq_en,
  output logic [WIDTH-1:0]     evt_pulse,
  output logic [WIDTH-1:0]     evt_sticky,
  output logic [WIDTH-1:0]     overflow,
  output logic                 irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0][FILT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]                  evt_pulse_q, evt_pulse_d;
  logic [WIDTH-1:0]                  evt_sticky_q, evt_sticky_d;
  logic [WIDTH-1:0]                  overflow_q, overflow_d;
  logic [WIDTH-1:0]                  sync_out;
  logic [WIDTH-1:0]                  trans;
  logic [WIDTH-1:0]                  qual;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift raw inputs one stage deeper into the synchroniser chain each cycle.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = data_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Glitch filter: accept a new level only after it has persisted filt_len+1 cycles.
  // The >= compare lets a lowered filt_len take effect mid-count without wrapping.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    trans  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_out[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len) begin
        filt_d[i] = sync_out[i];
        cnt_d[i]  = '0;
        trans[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  // Qualify accepted transitions by per-channel mode and update pulse/sticky/overflow.
  // Filtered state tracks even in mode 00 so enabling later never sees a stale level.
  always_comb begin
    qual = '0;
    for (int i = 0; i < WIDTH; i++) begin
      qual[i] = trans[i] & (filt_d[i] ? mode[2*i] : mode[2*i+1]);
    end
    evt_pulse_d  = qual;
    evt_sticky_d = (evt_sticky_q & ~clr) | qual;
    overflow_d   = ~clr & (overflow_q | (qual & evt_sticky_q));
  end

  // State registers; reset discards synchroniser, filter and flags immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      filt_q       <= '0;
      cnt_q        <= '0;
      evt_pulse_q  <= '0;
      evt_sticky_q <= '0;
      overflow_q   <= '0;
    end else begin
      sync_q       <= sync_d;
      filt_q       <= filt_d;
      cnt_q        <= cnt_d;
      evt_pulse_q  <= evt_pulse_d;
      evt_sticky_q <= evt_sticky_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evt_pulse  = evt_pulse_q;
  assign evt_sticky = evt_sticky_q;
  assign overflow   = overflow_q;
  assign irq        = |(evt_sticky_q & irq_en);

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed scenarios plus randomized traffic against a run-length reference model.
// Inputs change just after the falling edge; outputs are compared on the falling edge.
// Each cycle compares evt_pulse, evt_sticky, overflow and irq with the model.
module tb_edge_detect_multi;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int FW    = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   data_in = '0;
  logic [2*WIDTH-1:0] mode = '0;
  logic [FW-1:0]      filt_len = '0;
  logic [WIDTH-1:0]   clr = '0;
  logic [WIDTH-1:0]   irq_en = '0;
  logic [WIDTH-1:0]   evt_pulse, evt_sticky, overflow;
  logic               irq;

  int n_checks = 0;
  int n_errors = 0;

  edge_detect_multi #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .filt_len(filt_len),
    .clr(clr), .irq_en(irq_en), .evt_pulse(evt_pulse), .evt_sticky(evt_sticky),
    .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input samples delayed by SYNC clock edges, then a level
  // is accepted once it has been seen differing from the accepted level for
  // more than filt_len consecutive samples.
  logic [WIDTH-1:0] dq[$];
  logic [WIDTH-1:0] m_level, m_pulse, m_sticky, m_ovf;
  int               m_run[WIDTH];

  task automatic model_reset();
    dq.delete();
    m_level = '0; m_pulse = '0; m_sticky = '0; m_ovf = '0;
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [WIDTH-1:0] seen, ev, old_sticky;
    seen = (dq.size() >= SYNC) ? dq[SYNC-1] : '0;
    dq.push_front(data_in);
    while (dq.size() > SYNC) void'(dq.pop_back());
    ev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (seen[i] == m_level[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] > int'(filt_len)) begin
          m_level[i] = seen[i];
          m_run[i] = 0;
          if (seen[i] && mode[2*i]) ev[i] = 1'b1;
          if (!seen[i] && mode[2*i+1]) ev[i] = 1'b1;
        end
      end
    end
    old_sticky = m_sticky;
    m_pulse = ev;
    for (int i = 0; i < WIDTH; i++) begin
      if (ev[i]) m_sticky[i] = 1'b1;
      else if (clr[i]) m_sticky[i] = 1'b0;
      if (clr[i]) m_ovf[i] = 1'b0;
      else if (ev[i] && old_sticky[i]) m_ovf[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("pulse", 32'(evt_pulse), 32'(m_pulse));
    chk("sticky", 32'(evt_sticky), 32'(m_sticky));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("irq", 32'(irq), 32'(|(m_sticky & irq_en)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Assert reset between edges, confirm outputs drop without a clock, release on a falling edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pulse", 32'(evt_pulse), 32'h0);
    chk("rst_sticky", 32'(evt_sticky), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_all();
    clr = '1;
    cycle();
    clr = '0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("init_pulse", 32'(evt_pulse), 32'h0);
    chk("init_sticky", 32'(evt_sticky), 32'h0);
    chk("init_irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(4);

    // ch0 rising, filt_len 0: pulse after edge 3, irq follows
    filt_len = 0; mode = '0; mode[1:0] = 2'b01; irq_en = 8'h01;
    data_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("ch0_lat", 32'(evt_pulse[0]), 32'(k == 3));
    end
    chk("ch0_sticky", 32'(evt_sticky[0]), 32'h1);
    chk("ch0_irq", 32'(irq), 32'h1);
    data_in[0] = 1'b0;
    run(6);
    chk("ch0_fall_none", 32'(overflow[0]), 32'h0);
    clear_all();

    // ch2 both edges, filt_len 3: 3-cycle glitch dropped, 4-cycle level accepted
    filt_len = 3; mode[5:4] = 2'b11;
    data_in[2] = 1'b1; run(3); data_in[2] = 1'b0; run(8);
    chk("glitch_none", 32'(evt_sticky[2]), 32'h0);
    data_in[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk("ch2_rise_lat", 32'(evt_pulse[2]), 32'(k == 6));
    end
    data_in[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk("ch2_fall_lat", 32'(evt_pulse[2]), 32'(k == 6));
    end
    chk("ch2_ovf", 32'(overflow[2]), 32'h1);
    clear_all();

    // ch5 falling-only: overflow, clear, and clear coinciding with an event
    filt_len = 0; mode[11:10] = 2'b10;
    data_in[5] = 1'b1; run(4);
    chk("ch5_rise_none", 32'(evt_sticky[5]), 32'h0);
    data_in[5] = 1'b0; run(4);
    chk("ch5_sticky", 32'(evt_sticky[5]), 32'h1);
    data_in[5] = 1'b1; run(4); data_in[5] = 1'b0; run(4);
    chk("ch5_ovf", 32'(overflow[5]), 32'h1);
    clr[5] = 1'b1; cycle(); clr[5] = 1'b0;
    chk("ch5_clr_st", 32'(evt_sticky[5]), 32'h0);
    chk("ch5_clr_ov", 32'(overflow[5]), 32'h0);
    data_in[5] = 1'b1; run(4); data_in[5] = 1'b0; run(4);
    data_in[5] = 1'b1; run(4);
    data_in[5] = 1'b0; run(2);
    clr[5] = 1'b1; cycle(); clr[5] = 1'b0;
    chk("ch5_coin_pulse", 32'(evt_pulse[5]), 32'h1);
    chk("ch5_coin_st", 32'(evt_sticky[5]), 32'h1);
    chk("ch5_coin_ov", 32'(overflow[5]), 32'h0);

    // all channels rise together
    data_in = '0; run(6); clear_all();
    mode = 16'h5555; data_in = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("all_pulse", 32'(evt_pulse), (k == 3) ? 32'hFF : 32'h0);
    end
    chk("all_sticky", 32'(evt_sticky), 32'hFF);

    // ch1 tracks silently in mode 00, no spurious event when enabled
    data_in = '0; run(6); clear_all();
    mode = '0;
    for (int t = 0; t < 3; t++) begin
      data_in[1] = 1'b1; run(4); data_in[1] = 1'b0; run(4);
    end
    data_in[1] = 1'b1; run(6);
    mode[3:2] = 2'b01; run(6);
    chk("ch1_quiet", 32'(evt_sticky[1]), 32'h0);
    data_in[1] = 1'b0; run(6);
    data_in[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("ch1_rise", 32'(evt_pulse[1]), 32'(k == 3));
    end

    // reset mid filter count with ch3 held high
    data_in = '0; run(6); clear_all();
    filt_len = 3; mode = '0; mode[7:6] = 2'b01; irq_en = '1;
    data_in[3] = 1'b1; run(4);
    mid_reset();
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk("ch3_post_rst", 32'(evt_pulse[3]), 32'(k == 6));
    end

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) filt_len = FW'($urandom_range(5));
      if (c % 50 == 0) begin
        mode = 16'($urandom);
        irq_en = 8'($urandom);
      end
      clr = ($urandom_range(15) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(2) == 0) begin
        int ch;
        ch = $urandom_range(WIDTH - 1);
        data_in[ch] = ~data_in[ch];
      end
      if ($urandom_range(700) == 0) mid_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
